priority_arb: RTL and testbench

- Parametrised successor to the team's 4-to-2 registered priority encoder.
- Accepts N request lines and issues one registered grant: a legacy-encoded index Y, a one-hot grant, and a valid flag.
- Grants are held until the requester acks or drops its request.
- Supports two arbitration modes: fixed priority (bit 0 highest) and round-robin.
- Sits in front of shared resources (bus, memory port) that need arbitration between N clients.

---
 rtl/priority_arb_pkg.sv | 19 +
 rtl/priority_pick.sv | 34 +++
 rtl/priority_arb.sv | 167 ++++++++++++++++
 tb/tb_priority_arb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/priority_arb_pkg.sv
// Shared types and helpers for the priority_arb arbiter.
//   arb_state_e : arbiter FSM state encoding
//   N_DEFAULT   : default number of requesters
//   idx_encode  : legacy index encoding, Y = n-1-i for requester i
package priority_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned N_DEFAULT = 8;

  // Legacy encoder numbering: requester 0 maps to the highest code
  function automatic int unsigned idx_encode(input int unsigned i, input int unsigned n);
    return n - 1 - i;
  endfunction

endpackage

// File: rtl/priority_pick.sv
// Combinational find-first-set with a rotating start point.
// Ports:
//   req   [N]    : candidate request vector
//   start [IDXW] : index where the search begins (wraps mod N)
//   idx   [IDXW] : first set index at or after start (0 when none)
//   found        : at least one bit of req is set
module priority_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]             req,
  input  logic [$clog2(N)-1:0]     start,
  output logic [$clog2(N)-1:0]     idx,
  output logic                     found
);

  localparam int unsigned IDXW = $clog2(N);

  // Scan N positions beginning at start, wrapping past N-1 back to 0
  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < int'(N); k++) begin
      j = int'(start) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/priority_arb.sv
// Registered N-way arbiter with fixed-priority and round-robin modes.
// A grant is held until the owner acks or drops its request; on release the
// releasing requester is masked for that one arbitration so grants can move
// back-to-back without an idle cycle.
// Optional build macro: PRIORITY_ARB_STATS_EN adds grant_cnt and starve.
// Ports:
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-low reset
//   D         : request vector, bit 0 highest priority in fixed mode
//   rr_mode   : 0 fixed priority, 1 round-robin (sampled at arbitration edges)
//   ack       : current grantee releases (ignored while valid=0)
//   Y         : granted index, legacy encoding N-1-i
//   gnt       : one-hot grant
//   grant_cnt : (stats) saturating count of new grants
//   starve    : (stats) requester waited 2*N cycles without a grant
//   valid     : a grant is active
module priority_arb
  import priority_arb_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         D,
  input  logic                 rr_mode,
  input  logic                 ack,
  output logic [$clog2(N)-1:0] Y,
  output logic [N-1:0]         gnt,
`ifdef PRIORITY_ARB_STATS_EN
  output logic [15:0]          grant_cnt,
  output logic [N-1:0]         starve,
`endif
  output logic                 valid
);

  localparam int unsigned IDXW = $clog2(N);
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] y_q, y_d;
  logic            valid_q, valid_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic [N-1:0]    pick_req_c;
  logic [IDXW-1:0] pick_start_c;
  logic [IDXW-1:0] pick_idx_c;
  logic            pick_found_c;
  logic            release_c;
  logic            new_grant_c;

  // gnt_q is zero in IDLE, so one masked vector serves both states
  assign pick_req_c   = D & ~gnt_q;
  assign pick_start_c = rr_mode ? ptr_q : '0;

  priority_pick #(.N(N)) u_pick (
    .req   (pick_req_c),
    .start (pick_start_c),
    .idx   (pick_idx_c),
    .found (pick_found_c)
  );

  // Owner still requesting is visible as overlap of D with the held grant
  assign release_c = ack | ~(|(D & gnt_q));

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    y_d         = y_q;
    valid_d     = valid_q;
    ptr_d       = ptr_q;
    new_grant_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found_c) new_grant_c = 1'b1;
      end
      GRANT: begin
        if (release_c) begin
          if (pick_found_c) begin
            new_grant_c = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            y_d     = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_grant_c) begin
      state_d = GRANT;
      gnt_d   = ONE_HOT0 << pick_idx_c;
      y_d     = IDXW'(idx_encode(32'(pick_idx_c), N));
      valid_d = 1'b1;
      // Pointer moves only on round-robin grants, to the slot after the winner
      if (rr_mode) begin
        ptr_d = (pick_idx_c == IDXW'(N - 1)) ? '0 : pick_idx_c + IDXW'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Y     = y_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;

`ifdef PRIORITY_ARB_STATS_EN
  localparam int unsigned CW = $clog2(2 * N + 1);

  logic [15:0]   grant_cnt_q, grant_cnt_d;
  logic [N-1:0]  starve_q, starve_d;
  logic [CW-1:0] wait_q [N];
  logic [CW-1:0] wait_d [N];

  // Grant counter and per-requester wait counters
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    starve_d    = starve_q;
    if (new_grant_c && (grant_cnt_q != 16'hFFFF)) grant_cnt_d = grant_cnt_q + 16'd1;
    for (int i = 0; i < int'(N); i++) begin
      wait_d[i] = '0;
      if (D[i] && !gnt_q[i]) begin
        wait_d[i] = (wait_q[i] == CW'(2 * N)) ? wait_q[i] : wait_q[i] + CW'(1);
      end
      if (wait_d[i] == CW'(2 * N)) starve_d[i] = 1'b1;
      // A fresh grant to the requester clears its flag, even on the same edge
      if (new_grant_c && gnt_d[i]) starve_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_cnt_q <= '0;
      starve_q    <= '0;
      for (int i = 0; i < int'(N); i++) wait_q[i] <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      starve_q    <= starve_d;
      for (int i = 0; i < int'(N); i++) wait_q[i] <= wait_d[i];
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign starve    = starve_q;
`endif

endmodule

// File: tb/tb_priority_arb.sv
// Self-checking bench for priority_arb (N=8): directed test-plan sequences
// followed by randomized traffic, all compared against a behavioural model.
module tb_priority_arb;

  localparam int NREQ = 8;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] D;
  logic            rr_mode;
  logic            ack;
  logic [2:0]      Y;
  logic [NREQ-1:0] gnt;
  logic            valid;
`ifdef PRIORITY_ARB_STATS_EN
  logic [15:0]     grant_cnt;
  logic [NREQ-1:0] starve;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: who owns the resource (-1 = nobody) and the RR pointer
  int owner = -1;
  int rr_ptr = 0;

  priority_arb #(.N(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .D         (D),
    .rr_mode   (rr_mode),
    .ack       (ack),
    .Y         (Y),
    .gnt       (gnt),
`ifdef PRIORITY_ARB_STATS_EN
    .grant_cnt (grant_cnt),
    .starve    (starve),
`endif
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // First set bit of v searching from start, wrapping; -1 if none
  function automatic int first_from(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (start + k) % NREQ;
      if (((v >> j) & 8'd1) != 8'd0) return j;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge
  task automatic model_edge(input logic [NREQ-1:0] d, input logic rr, input logic a, input logic r);
    logic [NREQ-1:0] cand;
    int w;
    if (!r) begin
      owner  = -1;
      rr_ptr = 0;
      return;
    end
    if (owner < 0) begin
      cand = d;
    end else if (a || (((d >> owner) & 8'd1) == 8'd0)) begin
      cand = d & ~(8'd1 << owner);
    end else begin
      return;
    end
    w = first_from(cand, rr ? rr_ptr : 0);
    owner = w;
    if (w >= 0 && rr) rr_ptr = (w + 1) % NREQ;
  endtask

  // Present inputs, clock once, then compare all outputs at the falling edge
  task automatic step(input logic [NREQ-1:0] d, input logic rr, input logic a, input logic r);
    logic [NREQ-1:0] e_gnt;
    int e_y;
    D = d; rr_mode = rr; ack = a; rst = r;
    model_edge(d, rr, a, r);
    @(posedge clk);
    @(negedge clk);
    e_gnt = (owner >= 0) ? (8'd1 << owner) : 8'd0;
    e_y   = (owner >= 0) ? (NREQ - 1 - owner) : 0;
    check("valid", 32'(valid), (owner >= 0) ? 32'd1 : 32'd0);
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("Y", 32'(Y), 32'(e_y));
  endtask

  initial begin
    D = '0; rr_mode = 1'b0; ack = 1'b0; rst = 1'b0;

    // Reset wins over a full request vector
    step(8'hFF, 1'b0, 1'b0, 1'b0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    check("first_gnt", 32'(gnt), 32'h01);
    check("first_Y", 32'(Y), 32'd7);
    step(8'h00, 1'b0, 1'b0, 1'b1);

    // Fixed hold, no pre-emption by a higher-priority newcomer
    for (int i = 0; i < 6; i++) step(8'hA0, 1'b0, 1'b0, 1'b1);
    check("hold_Y", 32'(Y), 32'd2);
    step(8'hA2, 1'b0, 1'b0, 1'b1);
    check("no_preempt", 32'(gnt), 32'h20);

    // Fixed back-to-back via owner drop, then ack pulses
    step(8'h81, 1'b0, 1'b0, 1'b1);
    check("b2b_0", 32'(gnt), 32'h01);
    step(8'h81, 1'b0, 1'b1, 1'b1);
    check("b2b_1", 32'(gnt), 32'h80);
    check("b2b_1_Y", 32'(Y), 32'd0);
    step(8'h81, 1'b0, 1'b1, 1'b1);
    check("b2b_2", 32'(gnt), 32'h01);
    check("b2b_valid", 32'(valid), 32'd1);
    step(8'h00, 1'b0, 1'b0, 1'b1);

    // Round-robin rotation with ack held, including the wrap
    for (int k = 0; k <= NREQ; k++) begin
      logic [NREQ-1:0] exp_g;
      step(8'hFF, 1'b1, 1'b1, 1'b1);
      exp_g = 8'd1 << (k % NREQ);
      check("rr_seq", 32'(gnt), 32'(exp_g));
    end
    step(8'h00, 1'b1, 1'b0, 1'b1);

    // Drop release to IDLE, ack while idle ignored
    step(8'h08, 1'b0, 1'b0, 1'b1);
    check("drop_Y", 32'(Y), 32'd4);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    check("drop_valid", 32'(valid), 32'd0);
    step(8'h00, 1'b0, 1'b1, 1'b1);
    check("idle_ack", 32'(gnt), 32'h0);

    // Reset mid-grant clears the RR pointer
    step(8'h08, 1'b1, 1'b0, 1'b1);
    step(8'h08, 1'b1, 1'b0, 1'b0);
    check("midrst_valid", 32'(valid), 32'd0);
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    check("midrst_ptr", 32'(gnt), 32'h01);

    // Randomized traffic
    begin
      logic rr_r;
      rr_r = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        logic [NREQ-1:0] d_r;
        logic a_r, r_r;
        if ($urandom_range(0, 19) == 0) rr_r = ~rr_r;
        d_r = NREQ'($urandom);
        if ($urandom_range(0, 3) == 0) d_r = d_r & NREQ'($urandom);
        if ($urandom_range(0, 9) == 0) d_r = '0;
        a_r = ($urandom_range(0, 2) == 0);
        r_r = ($urandom_range(0, 99) != 0);
        step(d_r, rr_r, a_r, r_r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
